// File: rtl/mod_n_divider.sv
// Programmable modulo-N cycle counter / clock-enable divider with pulse or square output.
// Optional wrap counter output enabled by defining MOD_DIVIDER_WRAPCNT_EN.
module mod_n_divider #(
   parameter int WIDTH       = 4,
   parameter int MOD_DEFAULT = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             mode,
   input  logic             mod_wr,
   input  logic [WIDTH-1:0] mod_in,
   output logic [WIDTH-1:0] count,
   output logic             y,
   output logic             tc,
   output logic             mod_err
`ifdef MOD_DIVIDER_WRAPCNT_EN
   ,
   output logic [15:0]      wrap_cnt
`endif
);

   localparam logic [WIDTH-1:0] MOD_RST = MOD_DEFAULT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] TWO     = ONE + ONE;
   localparam logic [WIDTH:0]   ONE_W   = {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mod_q;
   logic [WIDTH-1:0] pend_q;
   logic             pending;
   logic [WIDTH-1:0] mod_last;
   logic [WIDTH-1:0] next_count;
   logic [WIDTH-1:0] mod_eff;
   logic [WIDTH:0]   half_mod;
   logic             next_y;
   logic             write_ok;
   logic             write_bad;
   logic             apply;

   // Moduli below 2 are rejected, so mod_q-1 never underflows.
   assign mod_last  = mod_q - ONE;
   assign tc        = en && (count == mod_last);
   assign write_ok  = mod_wr && (mod_in >= TWO);
   assign write_bad = mod_wr && (mod_in < TWO);
   assign apply     = tc && pending;

   // Next count, the modulus governing it, and the output level it implies.
   always_comb begin
      next_count = count;
      mod_eff    = mod_q;
      half_mod   = '0;
      next_y     = y;
      if (en) begin
         if (tc) begin
            next_count = '0;
         end else begin
            next_count = count + ONE;
         end
      end
      if (apply) begin
         mod_eff = pend_q;
      end
      half_mod = ({1'b0, mod_eff} + ONE_W) >> 1;
      if (en) begin
         if (mode) begin
            next_y = ({1'b0, next_count} < half_mod);
         end else begin
            next_y = (next_count == '0);
         end
      end
   end

   // Count, output and modulus registers; a new modulus only lands at a wrap.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         y       <= 1'b1;
         mod_q   <= MOD_RST;
         pend_q  <= MOD_RST;
         pending <= 1'b0;
         mod_err <= 1'b0;
      end else begin
         count   <= next_count;
         y       <= next_y;
         mod_err <= write_bad;
         if (apply) begin
            mod_q <= pend_q;
         end
         if (write_ok) begin
            pend_q  <= mod_in;
            pending <= 1'b1;
         end else if (apply) begin
            pending <= 1'b0;
         end
      end
   end

`ifdef MOD_DIVIDER_WRAPCNT_EN
   // Saturating count of wraps since reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrap_cnt <= '0;
      end else if (tc && (wrap_cnt != 16'hFFFF)) begin
         wrap_cnt <= wrap_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mod_n_divider.sv
// Self-checking bench for mod_n_divider: constant vector table, directed corner
// sequences, and randomized traffic against a period-level reference model.
module tb_mod_n_divider;

   logic       clk;
   logic       reset;
   logic       en;
   logic       mode;
   logic       mod_wr;
   logic [3:0] mod_in;
   logic [3:0] count;
   logic       y;
   logic       tc;
   logic       mod_err;
`ifdef MOD_DIVIDER_WRAPCNT_EN
   logic [15:0] wrap_cnt;
`endif

   int total = 0;
   int bad   = 0;

   // Reference model state
   int m_count, m_mod, m_pval, m_wraps;
   bit m_pend, m_y, m_err;

   typedef struct {
      bit en;
      bit mode;
      bit wr;
      int min;
      bit exp_tc;
      int exp_count;
      bit exp_y;
      bit exp_err;
   } vec_t;

   vec_t vecs[22];

   mod_n_divider #(.WIDTH(4), .MOD_DEFAULT(3)) dut (
      .clk(clk),
      .reset(reset),
      .en(en),
      .mode(mode),
      .mod_wr(mod_wr),
      .mod_in(mod_in),
      .count(count),
      .y(y),
      .tc(tc),
      .mod_err(mod_err)
`ifdef MOD_DIVIDER_WRAPCNT_EN
      ,
      .wrap_cnt(wrap_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      m_count = 0;
      m_mod   = 3;
      m_pval  = 3;
      m_pend  = 0;
      m_y     = 1;
      m_err   = 0;
      m_wraps = 0;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, " count"}, int'(count), m_count);
      checkOutput({tag, " y"}, int'(y), int'(m_y));
      checkOutput({tag, " mod_err"}, int'(mod_err), int'(m_err));
`ifdef MOD_DIVIDER_WRAPCNT_EN
      checkOutput({tag, " wrap_cnt"}, int'(wrap_cnt), m_wraps);
`endif
   endtask

   // One clock of stimulus, checked against the model (tc before the edge, registers after).
   task automatic applyStimulus(input bit e, input bit md, input bit w, input int mi, input string tag);
      bit wrap;
      @(negedge clk);
      en     = e;
      mode   = md;
      mod_wr = w;
      mod_in = mi[3:0];
      #1;
      wrap = e && (m_count == m_mod - 1);
      checkOutput({tag, " tc"}, int'(tc), int'(wrap));
      @(posedge clk);
      if (wrap) begin
         m_count = 0;
         if (m_wraps < 65535) m_wraps++;
         if (m_pend) begin
            m_mod  = m_pval;
            m_pend = 0;
         end
      end else if (e) begin
         m_count = m_count + 1;
      end
      if (w && mi >= 2) begin
         m_pval = mi;
         m_pend = 1;
      end
      m_err = w && (mi < 2);
      if (e) m_y = md ? (m_count < (m_mod + 1) / 2) : (m_count == 0);
      #1;
      checkModel(tag);
   endtask

   task automatic applyReset();
      @(negedge clk);
      en     = 0;
      mode   = 0;
      mod_wr = 0;
      mod_in = 0;
      reset  = 1;
      #2;
      reset  = 0;
      modelReset();
   endtask

   initial begin
      bit sqpat[8];
      reset  = 1;
      en     = 0;
      mode   = 0;
      mod_wr = 0;
      mod_in = 0;
      modelReset();

      // en, mode, wr, min, tc, count, y, err
      vecs[0]  = '{1, 0, 0, 0, 0, 1, 0, 0};
      vecs[1]  = '{1, 0, 0, 0, 0, 2, 0, 0};
      vecs[2]  = '{1, 0, 0, 0, 1, 0, 1, 0};
      vecs[3]  = '{1, 0, 0, 0, 0, 1, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 0, 1, 0, 0};
      vecs[5]  = '{0, 0, 0, 0, 0, 1, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 0};
      vecs[7]  = '{1, 0, 0, 0, 0, 2, 0, 0};
      vecs[8]  = '{1, 0, 0, 0, 1, 0, 1, 0};
      vecs[9]  = '{1, 0, 1, 5, 0, 1, 0, 0};
      vecs[10] = '{1, 0, 0, 0, 0, 2, 0, 0};
      vecs[11] = '{1, 0, 0, 0, 1, 0, 1, 0};
      vecs[12] = '{1, 0, 0, 0, 0, 1, 0, 0};
      vecs[13] = '{1, 0, 0, 0, 0, 2, 0, 0};
      vecs[14] = '{1, 0, 0, 0, 0, 3, 0, 0};
      vecs[15] = '{1, 0, 0, 0, 0, 4, 0, 0};
      vecs[16] = '{1, 0, 0, 0, 1, 0, 1, 0};
      vecs[17] = '{1, 0, 1, 1, 0, 1, 0, 1};
      vecs[18] = '{1, 0, 1, 0, 0, 2, 0, 1};
      vecs[19] = '{1, 0, 0, 0, 0, 3, 0, 0};
      vecs[20] = '{1, 0, 0, 0, 0, 4, 0, 0};
      vecs[21] = '{1, 0, 0, 0, 1, 0, 1, 0};

      #12;
      checkOutput("reset count", int'(count), 0);
      checkOutput("reset y", int'(y), 1);
      checkOutput("reset mod_err", int'(mod_err), 0);
      @(negedge clk);
      reset = 0;

      // Constant vector table
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         en     = vecs[i].en;
         mode   = vecs[i].mode;
         mod_wr = vecs[i].wr;
         mod_in = vecs[i].min[3:0];
         #1;
         checkOutput($sformatf("vec%0d tc", i), int'(tc), int'(vecs[i].exp_tc));
         @(posedge clk);
         #1;
         checkOutput($sformatf("vec%0d count", i), int'(count), vecs[i].exp_count);
         checkOutput($sformatf("vec%0d y", i), int'(y), int'(vecs[i].exp_y));
         checkOutput($sformatf("vec%0d mod_err", i), int'(mod_err), int'(vecs[i].exp_err));
      end

      // Square mode: mod 4 then mod 5, applied only at wraps
      applyReset();
      applyStimulus(1, 1, 1, 4, "sq wr4");
      applyStimulus(1, 1, 0, 0, "sq a");
      applyStimulus(1, 1, 0, 0, "sq b");
      sqpat = '{1, 0, 0, 1, 1, 0, 0, 1};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1, 0, 0, "sq4");
         checkOutput($sformatf("sq4 pattern %0d", i), int'(y), int'(sqpat[i]));
      end
      applyStimulus(1, 1, 1, 5, "sq wr5");
      applyStimulus(1, 1, 0, 0, "sq c");
      applyStimulus(1, 1, 0, 0, "sq d");
      applyStimulus(1, 1, 0, 0, "sq apply5");
      checkOutput("sq apply5 y", int'(y), 1);
      sqpat = '{1, 1, 0, 0, 1, 1, 1, 0};
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1, 1, 0, 0, "sq5");
         checkOutput($sformatf("sq5 pattern %0d", i), int'(y), int'(sqpat[i]));
      end

      // Asynchronous reset at count 2 with a write pending
      applyReset();
      applyStimulus(1, 0, 1, 7, "ar wr7");
      applyStimulus(1, 0, 0, 0, "ar step");
      checkOutput("ar pre count", int'(count), 2);
      @(negedge clk);
      en    = 0;
      #1;
      reset = 1;
      #1;
      checkOutput("ar async count", int'(count), 0);
      checkOutput("ar async y", int'(y), 1);
`ifdef MOD_DIVIDER_WRAPCNT_EN
      checkOutput("ar async wrap_cnt", int'(wrap_cnt), 0);
`endif
      #1;
      reset = 0;
      modelReset();
      for (int i = 0; i < 7; i++) begin
         applyStimulus(1, 0, 0, 0, "ar period3");
      end

      // Randomized traffic against the model
      applyReset();
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 5) == 0), int'($urandom_range(0, 15)), "rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
